// File: rtl/bitty_pkg.sv
// Shared types and encodings for the BittyPro instruction sequencer.
package bitty_pkg;

    localparam int unsigned INST_W  = 16;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT,
        ST_HALTED
    } state_e;

    localparam logic [INST_W-1:0] HALT_INST  = 16'hFFFF;
    localparam logic [1:0]        FMT_BRANCH = 2'b10;
    localparam logic [1:0]        COND_EQ    = 2'b00;
    localparam logic [1:0]        COND_GT    = 2'b01;
    localparam logic [1:0]        COND_LT    = 2'b10;
    localparam logic [1:0]        COND_NEVER = 2'b11;

endpackage

// File: rtl/bitty_watchdog.sv
// Execution watchdog: counts cycles while enabled; expired_o is high once
// the count has reached TIMEOUT-1, so the owner can act on the TIMEOUT-th cycle.
module bitty_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Next count: clear wins, otherwise increment up to LAST and hold there.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
        expired_d = (count_d == LAST);
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/bitty_sequencer.sv
// BittyPro instruction sequencer: fetch, decode, branch/halt resolution,
// ALU hand-off to the control unit and retired-instruction counting.
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INST_W-1:0]  imem_data,
    output logic [INST_W-1:0]  inst,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic [1:0]         cond_code,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [COUNT_W-1:0] instr_count
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INST_W-1:0]    inst_q, inst_d;
    logic                 req_q, req_d;
    logic                 start_q, start_d;
    logic                 halted_q, halted_d;
    logic                 error_q, error_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;

    logic                 wd_expired;
    logic                 is_halt;
    logic                 is_branch;
    logic                 br_taken;
    logic [ADDR_W-1:0]    pc_inc;
    logic [COUNT_W-1:0]   cnt_inc;

    // Decode of the held instruction and common increments.
    assign is_halt   = (inst_q == HALT_INST);
    assign is_branch = (inst_q[1:0] == FMT_BRANCH);
    assign br_taken  = (inst_q[3:2] == cond_code) && (inst_q[3:2] != COND_NEVER);
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign cnt_inc   = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);

    // Watchdog runs only while waiting on the control unit.
    bitty_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_WAIT),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        halted_d = halted_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else if (is_branch) begin
                    pc_d    = br_taken ? inst_q[ADDR_W+3:4] : pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = run ? ST_FETCH : ST_IDLE;
                end else begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (exec_done) begin
                    pc_d    = pc_inc;
                    cnt_d   = cnt_inc;
                    state_d = run ? ST_FETCH : ST_IDLE;
                end else if (wd_expired) begin
                    error_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d = (state_d == ST_FETCH);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            req_q    <= 1'b0;
            start_q  <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            req_q    <= req_d;
            start_q  <= start_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign exec_start  = start_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign instr_count = cnt_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed bench for bitty_sequencer with a transaction-level expectation model.
module tb_bitty_sequencer;
    import bitty_pkg::*;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;
    logic [15:0]       inst;
    logic              exec_start;
    logic              exec_done;
    logic [1:0]        cond_code;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       instr_count;

    bitty_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .cond_code   (cond_code),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected architectural state, advanced by the stimulus tasks.
    logic [ADDR_W-1:0] exp_pc;
    logic [15:0]       exp_inst;
    logic [15:0]       exp_cnt;
    logic              exp_req, exp_start, exp_busy, exp_halted, exp_error;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] branch_pc(input logic [ADDR_W-1:0] p,
                                                    input logic [15:0] ins,
                                                    input logic [1:0] cc);
        if (ins[3:2] == cc && ins[3:2] != 2'b11) return ins[ADDR_W+3:4];
        return p + ADDR_W'(1);
    endfunction

    task automatic retire(input logic [ADDR_W-1:0] new_pc);
        exp_pc  = new_pc;
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        if (run) begin
            exp_req = 1'b1;
        end else begin
            exp_req  = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_pc = '0; exp_inst = '0; exp_cnt = '0;
        exp_req = 1'b0; exp_start = 1'b0; exp_busy = 1'b0;
        exp_halted = 1'b0; exp_error = 1'b0;
    endtask

    // Drive ack/done for a few cycles and expect no architectural change.
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack  = 1'b1;
            imem_data = 16'h5A5A;
            exec_done = 1'b1;
            step();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
    endtask

    // One instruction from an outstanding fetch; k < 0 means done never comes.
    task automatic run_inst(input logic [15:0] data, input int lat, input int k,
                            input logic [1:0] cc, input bit drop_run);
        chk("fetch_ready", 16'(imem_req), 16'd1);
        cond_code = cc;
        for (int i = 0; i < lat; i++) begin
            exec_done = 1'b1;
            step();
        end
        exec_done = 1'b0;
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        exp_inst  = data;
        exp_req   = 1'b0;
        if (data == HALT_INST) begin
            step();
            exp_halted = 1'b1;
            exp_busy   = 1'b0;
        end else if (data[1:0] == FMT_BRANCH) begin
            step();
            retire(branch_pc(exp_pc, data, cc));
        end else begin
            step();
            exp_start = 1'b1;
            imem_ack  = 1'b1;
            imem_data = 16'hBEEF;
            if (drop_run) run = 1'b0;
            if (k < 0) begin
                for (int i = 0; i < int'(TIMEOUT); i++) begin
                    step();
                    imem_ack  = 1'b0;
                    exp_start = 1'b0;
                    if (i == int'(TIMEOUT) - 1) begin
                        exp_error  = 1'b1;
                        exp_halted = 1'b1;
                        exp_busy   = 1'b0;
                    end
                end
            end else begin
                for (int i = 0; i < k; i++) begin
                    step();
                    imem_ack  = 1'b0;
                    exp_start = 1'b0;
                end
                exec_done = 1'b1;
                step();
                exec_done = 1'b0;
                imem_ack  = 1'b0;
                exp_start = 1'b0;
                retire(exp_pc + ADDR_W'(1));
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",          16'(pc),         16'(exp_pc));
            chk("imem_addr",   16'(imem_addr),  16'(exp_pc));
            chk("inst",        inst,            exp_inst);
            chk("instr_count", instr_count,     exp_cnt);
            chk("imem_req",    16'(imem_req),   16'(exp_req));
            chk("exec_start",  16'(exec_start), 16'(exp_start));
            chk("busy",        16'(busy),       16'(exp_busy));
            chk("halted",      16'(halted),     16'(exp_halted));
            chk("error",       16'(error),      16'(exp_error));
        end
    end

    initial begin
        reset = 1'b0; run = 1'b1;
        imem_ack = 1'b0; imem_data = 16'h0; exec_done = 1'b0; cond_code = 2'b00;
        model_reset();

        // Reset held three cycles with run high.
        step();
        chk_en = 1'b1;
        step();
        step();
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_inst", inst, 16'h0000);
        reset = 1'b1;
        step();
        exp_req = 1'b1; exp_busy = 1'b1;
        chk("first_fetch_req", 16'(imem_req), 16'd1);
        chk("first_fetch_addr", 16'(imem_addr), 16'h0000);

        // ALU instruction, ack latency 2, done 3 cycles after start.
        run_inst(16'h2404, 2, 3, COND_EQ, 1'b0);
        chk("alu_pc", 16'(pc), 16'h0001);
        chk("alu_cnt", instr_count, 16'h0001);
        chk("alu_refetch", 16'(imem_addr), 16'h0001);

        // Branches: taken gt, not taken eq, never on 11, taken lt.
        run_inst(16'h0A56, 0, 0, COND_GT, 1'b0);
        chk("br_gt_taken", 16'(pc), 16'h00A5);
        run_inst(16'h0A56, 0, 0, COND_EQ, 1'b0);
        chk("br_not_taken", 16'(pc), 16'h00A6);
        run_inst(16'h0A5E, 0, 0, 2'b11, 1'b0);
        chk("br_never", 16'(pc), 16'h00A7);
        run_inst(16'h0FFA, 1, 0, COND_LT, 1'b0);
        chk("br_lt_taken", 16'(pc), 16'h00FF);
        chk("br_cnt", instr_count, 16'h0005);

        // PC wrap on ALU retire, then stop after instruction with run dropped.
        run_inst(16'h1230, 1, 1, COND_EQ, 1'b0);
        chk("pc_wrap", 16'(pc), 16'h0000);
        run_inst(16'h0001, 0, 2, COND_EQ, 1'b1);
        chk("run_drop_pc", 16'(pc), 16'h0001);
        chk("run_drop_busy", 16'(busy), 16'd0);
        chk("run_drop_cnt", instr_count, 16'h0007);
        noise(3);
        chk("idle_inst_kept", inst, 16'h0001);
        run = 1'b1;
        step();
        exp_req = 1'b1; exp_busy = 1'b1;

        // Reset mid-FETCH with ack in the same cycle.
        step();
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_data = 16'h1234;
        step();
        imem_ack = 1'b0;
        model_reset();
        chk("rst_mid_inst", inst, 16'h0000);
        chk("rst_mid_pc", 16'(pc), 16'h0000);
        reset = 1'b1;
        step();
        exp_req = 1'b1; exp_busy = 1'b1;

        // Watchdog expiry, then ignored ack/done.
        run_inst(16'h0004, 0, -1, COND_EQ, 1'b0);
        chk("wd_error", 16'(error), 16'd1);
        chk("wd_halted", 16'(halted), 16'd1);
        noise(4);
        chk("wd_pc_kept", 16'(pc), 16'h0000);
        chk("wd_cnt_kept", instr_count, 16'h0000);

        // Fresh reset, one ALU instruction, then halt.
        reset = 1'b0;
        step();
        model_reset();
        reset = 1'b1;
        step();
        exp_req = 1'b1; exp_busy = 1'b1;
        run_inst(16'h0010, 0, 1, COND_EQ, 1'b0);
        run_inst(HALT_INST, 1, 0, COND_EQ, 1'b0);
        chk("halt_flag", 16'(halted), 16'd1);
        chk("halt_pc", 16'(pc), 16'h0001);
        chk("halt_cnt", instr_count, 16'h0001);
        chk("halt_no_error", 16'(error), 16'd0);
        noise(3);
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
